div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 170 +++++++++++++++++
 tb/tb_div_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequential signed divider (restoring algorithm on magnitudes).
//
// A 2*WIDTH-bit signed dividend is divided by a WIDTH-bit signed divisor.
// The quotient truncates toward zero and the remainder takes the sign of the
// dividend. One operation takes 2*WIDTH CALC steps, a FIX step that applies
// the signs and loads the outputs, and a single DONE cycle.
//
// Handshake: start is sampled only while busy=0 (IDLE). The rising edge that
// samples start captures the operands; done pulses high for one cycle exactly
// 2*WIDTH+1 edges later. The results stay valid from done onward until the
// next operation's FIX step or reset. start while busy=1 is dropped.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   start          operation request (sampled in IDLE only)
//   dividend_in    [2*WIDTH-1:0] signed dividend
//   divisor_in     [WIDTH-1:0]   signed divisor
//   quotient_out   [2*WIDTH-1:0] signed quotient (registered)
//   remainder_out  [WIDTH-1:0]   signed remainder (registered)
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   div_zero       divisor was zero (registered with the results)
//   overflow       quotient not representable (registered with the results)
module div_seq #(
    parameter int WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]       divisor_in,
    output logic [2*WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]       remainder_out,
    output logic                   busy,
    output logic                   done,
    output logic                   div_zero,
    output logic                   overflow
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(W2) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Shift register: holds the dividend magnitude at capture and collects
    // quotient bits from the right as the steps proceed.
    logic [W2-1:0]    quo_sh;
    logic [WIDTH:0]   prem;      // partial remainder, WIDTH+1 bits
    logic [WIDTH:0]   dvs_mag;   // |divisor| needs WIDTH+1 bits for -2^(WIDTH-1)
    logic             dvd_neg;
    logic             dvs_neg;
    logic             zero_pend;
    logic             ovf_pend;
    logic [CW-1:0]    cnt;

    // Magnitudes computed one bit wider so the most-negative values negate
    // cleanly.
    logic [W2:0]      dvd_ext, dvd_abs;
    logic [WIDTH:0]   dvs_ext, dvs_abs;

    assign dvd_ext = {dividend_in[W2-1], dividend_in};
    assign dvd_abs = dividend_in[W2-1] ? (~dvd_ext + (W2+1)'(1)) : dvd_ext;
    assign dvs_ext = {divisor_in[WIDTH-1], divisor_in};
    assign dvs_abs = divisor_in[WIDTH-1] ? (~dvs_ext + (WIDTH+1)'(1)) : dvs_ext;

    // One restoring step. prem < dvs_mag <= 2^WIDTH, so the shifted value
    // fits in WIDTH+1 bits; one extra bit keeps the compare unambiguous.
    logic [WIDTH+1:0] shifted, step_rem;
    logic             step_ge;

    assign shifted  = {prem, quo_sh[W2-1]};
    assign step_ge  = (shifted >= {1'b0, dvs_mag});
    assign step_rem = step_ge ? (shifted - {1'b0, dvs_mag}) : shifted;

    // Sign correction applied in FIX.
    logic [W2-1:0]    q_fix;
    logic [WIDTH-1:0] r_fix;

    assign q_fix = (dvd_neg ^ dvs_neg) ? (~quo_sh + W2'(1)) : quo_sh;
    assign r_fix = dvd_neg ? (~prem[WIDTH-1:0] + WIDTH'(1)) : prem[WIDTH-1:0];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (cnt == CW'(W2 - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            quo_sh        <= '0;
            prem          <= '0;
            dvs_mag       <= '0;
            dvd_neg       <= 1'b0;
            dvs_neg       <= 1'b0;
            zero_pend     <= 1'b0;
            ovf_pend      <= 1'b0;
            cnt           <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
            div_zero      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_sh    <= dvd_abs[W2-1:0];
                        dvs_mag   <= dvs_abs;
                        dvd_neg   <= dividend_in[W2-1];
                        dvs_neg   <= divisor_in[WIDTH-1];
                        prem      <= '0;
                        cnt       <= '0;
                        zero_pend <= (divisor_in == '0);
                        // Only -2^(W2-1) / -1 produces an unrepresentable quotient.
                        ovf_pend  <= (dividend_in == {1'b1, {(W2-1){1'b0}}}) &&
                                     (divisor_in == {WIDTH{1'b1}});
                    end
                end
                CALC: begin
                    quo_sh <= {quo_sh[W2-2:0], step_ge};
                    prem   <= step_rem[WIDTH:0];
                    cnt    <= cnt + CW'(1);
                end
                FIX: begin
                    if (zero_pend) begin
                        quotient_out  <= '0;
                        remainder_out <= '0;
                        div_zero      <= 1'b1;
                        overflow      <= 1'b0;
                    end else begin
                        // In the overflow case the magnitude 2^(W2-1) passes
                        // through unnegated and reads back as -2^(W2-1).
                        quotient_out  <= q_fix;
                        remainder_out <= r_fix;
                        div_zero      <= 1'b0;
                        overflow      <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend_in;
  logic [3:0] divisor_in;
  logic [7:0] quotient_out;
  logic [3:0] remainder_out;
  logic       busy, done, div_zero, overflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[11];

  div_seq #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .quotient_out(quotient_out), .remainder_out(remainder_out),
    .busy(busy), .done(done), .div_zero(div_zero), .overflow(overflow)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Waits for IDLE, presents operands with start, returns just after edge E0.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    int g;
    @(negedge clock);
    g = 0;
    while (busy && g < 50) begin
      @(negedge clock);
      g++;
    end
    dividend_in = a;
    divisor_in  = b;
    start       = 1'b1;
    @(posedge clock);
  endtask

  // Drops start, scrambles inputs, waits for done and checks latency/results.
  task automatic collect(input vec_t v, input string tag);
    int lat;
    @(negedge clock);
    start       = 1'b0;
    dividend_in = 8'($urandom_range(0, 255));
    divisor_in  = 4'($urandom_range(0, 15));
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'd9);
    chk({tag, ".q"}, 32'(quotient_out), 32'(v.q));
    chk({tag, ".r"}, 32'(remainder_out), 32'(v.r));
    chk({tag, ".div_zero"}, 32'(div_zero), 32'(v.dz));
    chk({tag, ".overflow"}, 32'(overflow), 32'(v.ov));
    @(posedge clock);
    #1;
    chk({tag, ".done_pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int lat;
    int lat2;
    int seen;
    vec_t v;

    //              dvd     dvs    q      r     dz    ov
    vecs[0]  = '{8'hEE, 4'hD, 8'h06, 4'h0, 1'b0, 1'b0}; // -18 / -3
    vecs[1]  = '{8'h07, 4'h2, 8'h03, 4'h1, 1'b0, 1'b0}; //   7 /  2
    vecs[2]  = '{8'hF9, 4'h2, 8'hFD, 4'hF, 1'b0, 1'b0}; //  -7 /  2
    vecs[3]  = '{8'h07, 4'hE, 8'hFD, 4'h1, 1'b0, 1'b0}; //   7 / -2
    vecs[4]  = '{8'hF9, 4'hE, 8'h03, 4'hF, 1'b0, 1'b0}; //  -7 / -2
    vecs[5]  = '{8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1}; // -128 / -1
    vecs[6]  = '{8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0}; // -128 / -8
    vecs[7]  = '{8'h7F, 4'h7, 8'h12, 4'h1, 1'b0, 1'b0}; // 127 /  7
    vecs[8]  = '{8'h2D, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0}; //  45 /  0
    vecs[9]  = '{8'h80, 4'h7, 8'hEE, 4'hE, 1'b0, 1'b0}; // -128 / 7
    vecs[10] = '{8'h64, 4'h8, 8'hF4, 4'h4, 1'b0, 1'b0}; // 100 / -8

    reset = 1'b1;
    start = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset.outputs",
        32'({quotient_out, remainder_out, busy, done, div_zero, overflow}), 32'd0);

    // First start accepted on the first edge with reset low.
    @(negedge clock);
    reset       = 1'b0;
    dividend_in = vecs[0].dvd;
    divisor_in  = vecs[0].dvs;
    start       = 1'b1;
    @(posedge clock);
    #1;
    chk("first_start.busy", 32'(busy), 32'd1);
    collect(vecs[0], "vec0");

    for (int i = 1; i < 11; i++) begin
      launch(vecs[i].dvd, vecs[i].dvs);
      collect(vecs[i], $sformatf("vec%0d", i));
    end

    // Results hold after done.
    repeat (5) @(posedge clock);
    #1;
    chk("hold.q", 32'(quotient_out), 32'(vecs[10].q));
    chk("hold.r", 32'(remainder_out), 32'(vecs[10].r));

    // start re-pulsed with new operands at E4 is ignored.
    launch(8'h07, 4'h2);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      start = (k == 4);
      if (k == 4) begin
        dividend_in = 8'hF9;
        divisor_in  = 4'hE;
      end
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("busy_start.latency", 32'(lat), 32'd9);
    chk("busy_start.q", 32'(quotient_out), 32'h03);
    chk("busy_start.r", 32'(remainder_out), 32'h1);
    @(posedge clock);
    #1;
    chk("busy_start.not_queued", 32'(busy), 32'd0);

    // Reset at E5 aborts the operation.
    launch(8'hEE, 4'hD);
    seen = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      start = 1'b0;
      reset = (k == 5);
      @(posedge clock);
      #1;
      if (k == 5)
        chk("midreset.outputs",
            32'({quotient_out, remainder_out, busy, done, div_zero, overflow}), 32'd0);
      if (done || busy) seen++;
    end
    chk("midreset.no_done", 32'(seen), 32'd4);

    // Fresh start after reset.
    launch(vecs[7].dvd, vecs[7].dvs);
    collect(vecs[7], "after_reset");

    // Reset has priority over start on the same edge.
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    dividend_in = 8'h07;
    divisor_in  = 4'h2;
    @(posedge clock);
    #1;
    chk("reset_prio.busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_prio.idle", 32'(busy), 32'd0);

    // start held high: back-to-back operations with one IDLE cycle between.
    launch(8'h7F, 4'h7);
    @(negedge clock);
    dividend_in = 8'hF9;
    divisor_in  = 4'h2;
    lat = -1;
    lat2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (k == 10) chk("b2b.idle_gap", 32'(busy), 32'd0);
      if (done && lat < 0) begin
        lat = k;
        chk("b2b.q1", 32'(quotient_out), 32'h12);
        chk("b2b.r1", 32'(remainder_out), 32'h1);
      end else if (done && lat >= 0) begin
        lat2 = k;
        break;
      end
    end
    @(negedge clock);
    start = 1'b0;
    chk("b2b.latency1", 32'(lat), 32'd9);
    chk("b2b.latency2", 32'(lat2), 32'd20);
    chk("b2b.q2", 32'(quotient_out), 32'hFD);
    chk("b2b.r2", 32'(remainder_out), 32'hF);

    v = vecs[8];
    launch(v.dvd, v.dvs);
    collect(v, "final_dz");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
